raxm_mul_arbiter: RTL and testbench

RAXM_MUL_ARBITER -- requirements
Module: raxm_mul_arbiter

---
 rtl/raxm_mul_arbiter.sv | 137 +++++++++++++
 tb/tb_raxm_mul_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/raxm_mul_arbiter.sv
// Purpose : round-robin arbiter sharing one multi-cycle multiplier between two requesters, with abort on a stuck job.
// Latency : accept edge T -> mul_start at T+1 -> mul_done sampled at T+1+k -> rspN_valid at T+2+k (sampled edges).
// Backpres: one job in flight; req*_ready only in IDLE; rsp held stable until rspN_ready; no accept in the RESP handshake cycle.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   reqN_valid/ready/a/b         operand channel per requester (N = 0 Wishbone side, 1 logic-analyzer side)
//   rspN_valid/ready/data/err    result channel per requester; err=1 marks a timed-out job (data 0)
//   mul_start/mul_a/mul_b        multiplier issue (start is a one-cycle pulse)
//   mul_done/mul_result          multiplier completion, honoured only while waiting
//   busy, grant_id, err_timeout  status: job in progress, current owner, one-cycle abort pulse
module raxm_mul_arbiter #(
    parameter int OP_W    = 16,
    parameter int RES_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_a,
    input  logic [OP_W-1:0]  req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [RES_W-1:0] rsp0_data,
    output logic             rsp0_err,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_a,
    input  logic [OP_W-1:0]  req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [RES_W-1:0] rsp1_data,
    output logic             rsp1_err,
    output logic             mul_start,
    output logic [OP_W-1:0]  mul_a,
    output logic [OP_W-1:0]  mul_b,
    input  logic             mul_done,
    input  logic [RES_W-1:0] mul_result,
    output logic             busy,
    output logic             grant_id,
    output logic             err_timeout
);

    localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic [TMR_W-1:0] timer;
    logic [OP_W-1:0]  op_a, op_b;
    logic [RES_W-1:0] res_q;
    logic             err_q;

    logic pick;      // requester chosen this cycle if a request is accepted
    logic accept;
    logic done_hit;
    logic tmo_hit;
    logic rsp_hs;

    always_comb begin
        state_nxt = state;
        // Tie goes to whoever was not served last; a lone request wins outright.
        pick      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept    = (state == IDLE) && (req0_valid || req1_valid);
        done_hit  = (state == WAIT) && mul_done;
        // A completion arriving on the timeout cycle wins over the abort.
        tmo_hit   = (state == WAIT) && !mul_done && (timer == TMO);
        rsp_hs    = (state == RESP) && (grant_id ? rsp1_ready : rsp0_ready);

        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done_hit || tmo_hit) state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            timer      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant_id <= pick;
                op_a     <= pick ? req1_a : req0_a;
                op_b     <= pick ? req1_b : req0_b;
            end
            if (state == ISSUE) begin
                timer <= '0;
            end
            if (state == WAIT) begin
                if (mul_done) begin
                    res_q <= mul_result;
                    err_q <= 1'b0;
                end else if (tmo_hit) begin
                    res_q <= '0;
                    err_q <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
            if (rsp_hs) begin
                last_grant <= grant_id;
            end
        end
    end

    // Ready is combinational on valid, so gate it with reset to keep it low while reset is held.
    assign req0_ready  = wb_rst_ni && accept && !pick;
    assign req1_ready  = wb_rst_ni && accept && pick;

    assign mul_start   = (state == ISSUE);
    assign mul_a       = ((state == ISSUE) || (state == WAIT)) ? op_a : '0;
    assign mul_b       = ((state == ISSUE) || (state == WAIT)) ? op_b : '0;

    assign rsp0_valid  = (state == RESP) && !grant_id;
    assign rsp1_valid  = (state == RESP) && grant_id;
    assign rsp0_data   = rsp0_valid ? res_q : '0;
    assign rsp1_data   = rsp1_valid ? res_q : '0;
    assign rsp0_err    = rsp0_valid && err_q;
    assign rsp1_err    = rsp1_valid && err_q;

    assign busy        = (state != IDLE);
    assign err_timeout = tmo_hit;

endmodule

// File: tb/tb_raxm_mul_arbiter.sv
// Purpose : directed self-checking bench for raxm_mul_arbiter (single job, ties, backpressure, timeout, reset mid-job).
// Latency : inputs driven and outputs sampled around the falling edge; one job step per clock.
// Backpres: rsp ready stalls applied from the bench; every wait is a fixed number of cycles.
module tb_raxm_mul_arbiter;

    localparam int OP_W    = 16;
    localparam int RES_W   = 32;
    localparam int TIMEOUT = 15;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
    logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
    logic [OP_W-1:0]  req0_a, req0_b, req1_a, req1_b, mul_a, mul_b;
    logic [RES_W-1:0] rsp0_data, rsp1_data, mul_result;
    logic             mul_start, mul_done, busy, grant_id, err_timeout;
    logic [104:0]     outs;

    int total = 0;
    int bad   = 0;

    raxm_mul_arbiter #(.OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_data   (rsp0_data),
        .rsp0_err    (rsp0_err),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_data   (rsp1_data),
        .rsp1_err    (rsp1_err),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_result  (mul_result),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    assign outs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
                   rsp0_err, rsp1_err, mul_start, mul_a, mul_b, busy, err_timeout};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete job for requester g, whose valid/operands the caller has already set.
    // k = WAIT cycles until mul_done (1..TIMEOUT+1); k = 0 means the multiplier never answers.
    task automatic job(input logic g, input logic [15:0] a, input logic [15:0] b,
                       input int k, input logic [31:0] res, input int stall);
        int          n;
        logic [31:0] exp_d;
        logic        exp_e;
        n     = (k == 0) ? TIMEOUT + 1 : k;
        exp_d = (k == 0) ? 32'h0 : res;
        exp_e = (k == 0);
        #1;
        chk("acc_ready", g ? req1_ready : req0_ready, 1);
        chk("acc_other", g ? req0_ready : req1_ready, 0);
        @(negedge clk);
        chk("issue_start", mul_start, 1);
        chk("issue_a", mul_a, a);
        chk("issue_b", mul_b, b);
        chk("issue_gnt", grant_id, g);
        chk("issue_busy", busy, 1);
        chk("issue_rdy", req0_ready | req1_ready, 0);
        for (int c = 2; c <= n + 1; c++) begin
            @(negedge clk);
            if (c == n + 1 && k != 0) begin
                mul_done   = 1'b1;
                mul_result = res;
            end
            #1;
            chk("wait_start", mul_start, 0);
            chk("wait_rsp", rsp0_valid | rsp1_valid, 0);
            chk("wait_tmo", err_timeout, (k == 0 && c == n + 1));
            if (c == n + 1) begin
                chk("hold_a", mul_a, a);
                chk("hold_b", mul_b, b);
            end
        end
        @(negedge clk);
        mul_done   = 1'b0;
        mul_result = 32'hDEAD_BEEF;
        #1;
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                @(negedge clk);
                #1;
            end
            chk("rsp_valid", g ? rsp1_valid : rsp0_valid, 1);
            chk("rsp_other", g ? rsp0_valid : rsp1_valid, 0);
            chk("rsp_data", g ? rsp1_data : rsp0_data, exp_d);
            chk("rsp_other_data", g ? rsp0_data : rsp1_data, 0);
            chk("rsp_err", g ? rsp1_err : rsp0_err, exp_e);
            chk("rsp_tmo", err_timeout, 0);
            chk("rsp_start", mul_start, 0);
            chk("rsp_rdy", req0_ready | req1_ready, 0);
        end
        if (g) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        #1;
        chk("hs_no_accept", req0_ready | req1_ready, 0);
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        chk("post_valid", rsp0_valid | rsp1_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_data", rsp0_data | rsp1_data, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        mul_done   = 1'b0;
        mul_result = '0;

        // Reset: every output low even with a request pending.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs_zero", |outs, 0);
        chk("rst_grant", grant_id, 0);
        req0_valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_outs_zero", |outs, 0);

        // Single job on requester 0: 3 * 5 = 0xF, done after 3 WAIT cycles.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'h0005;
        job(1'b0, 16'h0003, 16'h0005, 3, 32'h0000_000F, 0);
        req0_valid = 1'b0;

        // Tie (last grant 0 -> requester 1) with a 4-cycle response stall.
        req0_valid = 1'b1; req0_a = 16'h0007; req0_b = 16'h0009;
        req1_valid = 1'b1; req1_a = 16'h1234; req1_b = 16'h0010;
        job(1'b1, 16'h1234, 16'h0010, 2, 32'h0001_2340, 4);
        req1_valid = 1'b0;

        // Requester 0 re-accepted the cycle after return to IDLE; multiplier never answers.
        job(1'b0, 16'h0007, 16'h0009, 0, 32'h0, 0);
        req0_valid = 1'b0;

        // Completion exactly on the timeout cycle: normal result, no error.
        req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h8000;
        job(1'b1, 16'h0002, 16'h8000, TIMEOUT + 1, 32'h0001_0000, 0);
        req1_valid = 1'b0;

        // Reset in the middle of WAIT, then a late mul_done.
        req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_wait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", |outs, 0);
        chk("mid_rst_grant", grant_id, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        mul_done   = 1'b1;
        mul_result = 32'hFFFE_0001;
        @(negedge clk);
        mul_done   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("late_done_outs", |outs, 0);
            @(negedge clk);
        end

        // Continuous tie after reset: 0, 1, 0, 1.
        req0_valid = 1'b1; req0_a = 16'h0010; req0_b = 16'h0020;
        req1_valid = 1'b1; req1_a = 16'h00FF; req1_b = 16'h0101;
        job(1'b0, 16'h0010, 16'h0020, 1, 32'h0000_0200, 0);
        job(1'b1, 16'h00FF, 16'h0101, 2, 32'h0000_FFFF, 0);
        job(1'b0, 16'h0010, 16'h0020, 1, 32'h0000_0200, 0);
        job(1'b1, 16'h00FF, 16'h0101, 2, 32'h0000_FFFF, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
